alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue controller sitting directly upstream of the 8-bit ALU. It buffers operation requests `{op, a, b}` in a small FIFO and issues one per clock onto the ALU select/operand inputs. It owns the architectural carry flag: it supplies carry-in to the ALU and updates the flag from the ALU carry-out. It also captures each ALU result and returns it, tagged, on a result strobe.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
W, 8, operand/result width (matches ALU datapath)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept (= not full)
req_op  in  4  ALU select code
req_a  in  W  operand A
req_b  in  W  operand B
alu_s  out  4  ALU select, registered
alu_a  out  W  ALU operand A, registered
alu_b  out  W  ALU operand B, registered
alu_cin  out  1  carry flag driven to ALU carry-in (combinational from flag register)
alu_f  in  W  ALU result
alu_cout  in  1  ALU carry-out
flag_wr  in  1  software write of carry flag
flag_val  in  1  value for flag_wr
res_valid  out  1  one-cycle result strobe
res_f  out  W  captured result
res_op  out  4  op code of the result
res_carry  out  1  carry flag after this op
res_err  out  1  op code was 14 or 15
carry_flag  out  1  current carry flag
busy  out  1  FIFO non-empty or op in flight

Behaviour:
- Reset (async, `rst_n`=0) clears the FIFO (count 0, pointers 0) and all stage-valid bits.
- Reset forces: `alu_s`=0, `alu_a`=0, `alu_b`=0, `res_*`=0, `res_valid`=0, `carry_flag`=0, `busy`=0, `req_ready`=1.
- Reset mid-operation drops all queued and in-flight ops; no `res_valid` for them after release.
- Accept: push when `req_valid && req_ready`. `req_ready` = count<DEPTH, from registered count, so there is no combinational path from `req_valid`.
- Pointers wrap modulo DEPTH. Push and pop in the same cycle leave count unchanged.
- Pipeline:
  - I (issue register, drives `alu_*`)
  - X (ALU registers its result)
  - C (capture into `res_*`)
- Pop into I occurs when FIFO non-empty and no hazard. Every cycle I is loaded: with the popped entry, or with a bubble whose valid=0 (`alu_s` holds the last value).
- Latency with empty pipe and no hazard: request accepted at edge t; issued at t+1; ALU result at t+2; `res_valid`=1 for the cycle after edge t+3.
- Throughput is one op per cycle. There is no result backpressure; the consumer must take `res_valid` when it is high.
- Carry producers are ops 1, 2, 3, 4. At C, `carry_flag` <= `alu_cout`.
- Ops 0 and 5-13 leave the flag unchanged.
- Carry consumers are ops 3, 12, 13. They use `alu_cin`=`carry_flag`.
- Hazard:
  - A consumer at the FIFO head may not pop while any producer is valid in I or X.
  - It stalls, inserting bubbles, until the producer reaches C.
  - Back-to-back producer followed by consumer therefore gives 2 bubble cycles.
  - Non-consumers never stall.
- `flag_wr` at an edge sets `carry_flag`=`flag_val`. If a producer captures at the same edge, `flag_wr` wins; that result's `res_carry` still reports `alu_cout`.
- Ops 14 and 15 are issued normally. The result has `res_err`=1 and `res_f`=0, and the flag is unchanged.
- `res_carry` = the flag value resulting from that op (new value for producers, current flag otherwise).
- `busy` = count!=0 | I.valid | X.valid.

Test Plan:
- Reset then a single op=2, a=8'hF0, b=8'h20 -> `res_valid` 3 cycles after accept, `res_f`=8'h10, `res_carry`=1, `carry_flag`=1.
- Op=2 a=8'hFF b=8'h01, then immediately op=3 a=8'h01 b=8'h01 -> op 3 issue delayed 2 cycles; `res_f`=8'h03, `res_carry`=0.
- Push 5 requests back-to-back with DEPTH=4 and no drain stall -> `req_ready` drops only when count=4; all 5 results in order, with no loss or duplication across pointer wrap.
- `flag_wr`=1 `flag_val`=1, then op=12 a=8'h02 -> `res_f`=8'h81, flag stays 1. Then `flag_wr` coincident with an op=1 a=8'hFF capture -> `carry_flag`=`flag_val`, `res_carry`=1.
- op=15 -> `res_err`=1, `res_f`=0, flag unchanged. Op stream 0,7,8,9,10,11 produces one result per cycle with no bubbles.
- Assert `rst_n`=0 with 3 ops queued and 2 in flight -> all outputs reach reset values asynchronously; no `res_valid` after release; `req_ready`=1.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// Issue controller in front of the 8-bit ALU. It queues requests, issues one per cycle,
// owns the carry flag (interlocking carry consumers behind producers) and returns tagged results.
module alu_issue_ctrl #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic [3:0]   alu_s,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic         alu_cin,
    input  logic [W-1:0] alu_f,
    input  logic         alu_cout,
    input  logic         flag_wr,
    input  logic         flag_val,
    output logic         res_valid,
    output logic [W-1:0] res_f,
    output logic [3:0]   res_op,
    output logic         res_carry,
    output logic         res_err,
    output logic         carry_flag,
    output logic         busy
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = 4 + 2 * W;

    function automatic logic is_producer(input logic [3:0] op);
        is_producer = (op >= 4'd1) && (op <= 4'd4);
    endfunction

    function automatic logic is_consumer(input logic [3:0] op);
        is_consumer = (op == 4'd3) || (op == 4'd12) || (op == 4'd13);
    endfunction

    function automatic logic is_err(input logic [3:0] op);
        is_err = (op >= 4'd14);
    endfunction

    logic [EW-1:0] fifo_mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          i_valid_r;
    logic          x_valid_r;
    logic [3:0]    alu_s_r;
    logic [3:0]    x_op_r;
    logic [W-1:0]  alu_a_r;
    logic [W-1:0]  alu_b_r;
    logic          res_valid_r;
    logic [W-1:0]  res_f_r;
    logic [3:0]    res_op_r;
    logic          res_carry_r;
    logic          res_err_r;
    logic          carry_flag_r;

    logic [EW-1:0] head_s;
    logic [3:0]    head_op_s;
    logic          not_full_s;
    logic          not_empty_s;
    logic          hazard_s;
    logic          push_s;
    logic          pop_s;

    // Head decode, carry interlock and push/pop decisions
    always_comb begin
        head_s      = fifo_mem_r[rd_ptr_r];
        head_op_s   = head_s[EW-1 -: 4];
        not_full_s  = (count_r != CW'(DEPTH));
        not_empty_s = (count_r != {CW{1'b0}});
        // A consumer must see the flag after every older producer has reached capture.
        hazard_s    = is_consumer(head_op_s) &&
                      ((i_valid_r && is_producer(alu_s_r)) ||
                       (x_valid_r && is_producer(x_op_r)));
        push_s      = req_valid && not_full_s;
        pop_s       = not_empty_s && !hazard_s;
    end

    // FIFO storage; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {req_op, req_a, req_b};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // I and X stages; a bubble keeps the last operands on the ALU inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_valid_r <= 1'b0;
            alu_s_r   <= 4'd0;
            alu_a_r   <= {W{1'b0}};
            alu_b_r   <= {W{1'b0}};
            x_valid_r <= 1'b0;
            x_op_r    <= 4'd0;
        end else begin
            i_valid_r <= pop_s;
            if (pop_s) begin
                alu_s_r <= head_op_s;
                alu_a_r <= head_s[2*W-1 -: W];
                alu_b_r <= head_s[W-1:0];
            end
            x_valid_r <= i_valid_r;
            x_op_r    <= alu_s_r;
        end
    end

    // C stage: result capture and carry-flag ownership (software write wins)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_r  <= 1'b0;
            res_f_r      <= {W{1'b0}};
            res_op_r     <= 4'd0;
            res_carry_r  <= 1'b0;
            res_err_r    <= 1'b0;
            carry_flag_r <= 1'b0;
        end else begin
            res_valid_r <= x_valid_r;
            if (x_valid_r) begin
                res_op_r    <= x_op_r;
                res_err_r   <= is_err(x_op_r);
                res_f_r     <= is_err(x_op_r) ? {W{1'b0}} : alu_f;
                res_carry_r <= is_producer(x_op_r) ? alu_cout : carry_flag_r;
            end
            if (flag_wr) begin
                carry_flag_r <= flag_val;
            end else if (x_valid_r && is_producer(x_op_r)) begin
                carry_flag_r <= alu_cout;
            end
        end
    end

    assign req_ready  = not_full_s;
    assign alu_s      = alu_s_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_cin    = carry_flag_r;
    assign res_valid  = res_valid_r;
    assign res_f      = res_f_r;
    assign res_op     = res_op_r;
    assign res_carry  = res_carry_r;
    assign res_err    = res_err_r;
    assign carry_flag = carry_flag_r;
    assign busy       = not_empty_s | i_valid_r | x_valid_r;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a registered behavioural ALU beside it.
module tb_alu_issue_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_op;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [3:0] alu_s;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic       alu_cin;
    logic [7:0] alu_f = 8'h00;
    logic       alu_cout = 1'b0;
    logic       flag_wr;
    logic       flag_val;
    logic       res_valid;
    logic [7:0] res_f;
    logic [3:0] res_op;
    logic       res_carry;
    logic       res_err;
    logic       carry_flag;
    logic       busy;

    typedef struct packed {
        logic [3:0] op;
        logic [7:0] f;
        logic       c;
        logic       e;
    } exp_t;

    exp_t sb[$];
    int   res_cyc[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_res = 0;
    int   last_wait = 0;

    alu_issue_ctrl #(.DEPTH(4), .W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_a(req_a), .req_b(req_b),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_f(alu_f), .alu_cout(alu_cout),
        .flag_wr(flag_wr), .flag_val(flag_val),
        .res_valid(res_valid), .res_f(res_f), .res_op(res_op),
        .res_carry(res_carry), .res_err(res_err),
        .carry_flag(carry_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input logic cin);
        case (op)
            4'd0:    alu_fn = {1'b0, a};
            4'd1:    alu_fn = {1'b0, a} + 9'd1;
            4'd2:    alu_fn = {1'b0, a} + {1'b0, b};
            4'd3:    alu_fn = {1'b0, a} + {1'b0, b} + {8'd0, cin};
            4'd4:    alu_fn = {1'b0, a} - {1'b0, b};
            4'd5:    alu_fn = {1'b0, a & b};
            4'd6:    alu_fn = {1'b0, a | b};
            4'd7:    alu_fn = {1'b0, a ^ b};
            4'd8:    alu_fn = {1'b0, ~a};
            4'd9:    alu_fn = {a, 1'b0};
            4'd10:   alu_fn = {a[0], 1'b0, a[7:1]};
            4'd11:   alu_fn = {1'b0, b};
            4'd12:   alu_fn = {a[0], cin, a[7:1]};
            4'd13:   alu_fn = {a, cin};
            default: alu_fn = {~cin, 8'hEE};
        endcase
    endfunction

    // Behavioural ALU: registers its result one cycle after the operands are presented
    always @(posedge clk) {alu_cout, alu_f} <= alu_fn(alu_s, alu_a, alu_b, alu_cin);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every result strobe is matched against the oldest expectation
    always @(negedge clk) begin
        if (res_valid) begin
            exp_t e;
            n_res++;
            res_cyc.push_back(cyc);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got op %0h f %0h with empty scoreboard", res_op, res_f);
            end else begin
                e = sb.pop_front();
                chk("res_op", 32'(res_op), 32'(e.op));
                chk("res_f", 32'(res_f), 32'(e.f));
                chk("res_carry", 32'(res_carry), 32'(e.c));
                chk("res_err", 32'(res_err), 32'(e.e));
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] f, input logic c, input logic e);
        exp_t x;
        int   n = 0;
        x.op = op; x.f = f; x.c = c; x.e = e;
        sb.push_back(x);
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        while (!req_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk("send_timeout", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        last_wait = n;
    endtask

    task automatic set_flag(input logic v);
        flag_wr = 1'b1; flag_val = v;
        @(posedge clk); #1;
        flag_wr = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(negedge clk); #1;
        chk({name, "_drained"}, 32'(sb.size()), 32'd0);
        chk({name, "_idle"}, 32'(busy), 32'd0);
    endtask

    task automatic check_reset_state(input string p);
        chk({p, "_alu_s"}, 32'(alu_s), 32'd0);
        chk({p, "_alu_a"}, 32'(alu_a), 32'd0);
        chk({p, "_alu_b"}, 32'(alu_b), 32'd0);
        chk({p, "_alu_cin"}, 32'(alu_cin), 32'd0);
        chk({p, "_res_valid"}, 32'(res_valid), 32'd0);
        chk({p, "_res_f"}, 32'(res_f), 32'd0);
        chk({p, "_res_op"}, 32'(res_op), 32'd0);
        chk({p, "_res_carry"}, 32'(res_carry), 32'd0);
        chk({p, "_res_err"}, 32'(res_err), 32'd0);
        chk({p, "_carry_flag"}, 32'(carry_flag), 32'd0);
        chk({p, "_busy"}, 32'(busy), 32'd0);
        chk({p, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int waits;
        int snap;
        rst_n = 1'b0; req_valid = 1'b0; req_op = 4'd0; req_a = 8'd0; req_b = 8'd0;
        flag_wr = 1'b0; flag_val = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single producer: latency and flag update
        send(4'd2, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("latency_early", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("latency_t3", 32'(res_valid), 32'd1);
        wait_idle("single");
        chk("single_flag", 32'(carry_flag), 32'd1);

        // Producer immediately followed by consumer: two bubbles
        res_cyc.delete();
        send(4'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        send(4'd3, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0);
        wait_idle("hazard");
        chk("hazard_count", 32'(res_cyc.size()), 32'd2);
        if (res_cyc.size() == 2) chk("hazard_gap", 32'(res_cyc[1] - res_cyc[0]), 32'd3);
        chk("hazard_flag", 32'(carry_flag), 32'd0);

        // Carry chain fills the FIFO; ready drops only once four entries are held
        waits = 0;
        send(4'd2, 8'h80, 8'h80, 8'h00, 1'b1, 1'b0); waits += last_wait;
        send(4'd3, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0); waits += last_wait;
        send(4'd3, 8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0); waits += last_wait;
        send(4'd3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0); waits += last_wait;
        send(4'd3, 8'h10, 8'h20, 8'h31, 1'b0, 1'b0); waits += last_wait;
        send(4'd3, 8'h7F, 8'h80, 8'hFF, 1'b0, 1'b0); waits += last_wait;
        chk("fill_no_early_stall", 32'(waits), 32'd0);
        chk("fill_ready_low", 32'(req_ready), 32'd0);
        send(4'd0, 8'hAA, 8'h00, 8'hAA, 1'b0, 1'b0);
        chk("fill_stall_cycles", 32'(last_wait), 32'd2);
        wait_idle("fill");

        // Non-consumer stream: one result per cycle
        res_cyc.delete();
        send(4'd0, 8'h5A, 8'h00, 8'h5A, 1'b0, 1'b0);
        send(4'd7, 8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0);
        send(4'd8, 8'h55, 8'h00, 8'hAA, 1'b0, 1'b0);
        send(4'd9, 8'h33, 8'h00, 8'h66, 1'b0, 1'b0);
        send(4'd10, 8'h81, 8'h00, 8'h40, 1'b0, 1'b0);
        send(4'd11, 8'h00, 8'hC3, 8'hC3, 1'b0, 1'b0);
        wait_idle("stream");
        chk("stream_count", 32'(res_cyc.size()), 32'd6);
        for (int i = 1; i < res_cyc.size(); i++) chk("stream_gap", 32'(res_cyc[i] - res_cyc[i-1]), 32'd1);

        // Software flag write feeds a rotate-through-carry; then write vs capture collision
        set_flag(1'b1);
        chk("flag_write", 32'(carry_flag), 32'd1);
        send(4'd12, 8'h02, 8'h00, 8'h81, 1'b1, 1'b0);
        wait_idle("rrc");
        chk("rrc_flag_kept", 32'(carry_flag), 32'd1);
        send(4'd1, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        flag_wr = 1'b1; flag_val = 1'b0;
        @(posedge clk); #1;
        flag_wr = 1'b0;
        chk("collide_strobe", 32'(res_valid), 32'd1);
        chk("collide_flag", 32'(carry_flag), 32'd0);
        wait_idle("collide");

        // Illegal op: zero result, error tag, flag untouched
        set_flag(1'b1);
        send(4'd15, 8'h12, 8'h34, 8'h00, 1'b1, 1'b1);
        wait_idle("err");
        chk("err_flag_kept", 32'(carry_flag), 32'd1);

        // Asynchronous reset with work queued and in flight
        send(4'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        send(4'd3, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0);
        send(4'd3, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        send(4'd3, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        send(4'd3, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        chk("pre_reset_flag", 32'(carry_flag), 32'd1);
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_reset_state("async_reset");
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        snap = n_res;
        repeat (10) @(posedge clk);
        #1;
        chk("no_res_after_reset", 32'(n_res - snap), 32'd0);
        chk("post_reset_ready", 32'(req_ready), 32'd1);
        chk("post_reset_busy", 32'(busy), 32'd0);
        send(4'd0, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b0);
        wait_idle("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
